ip_accum_stage: RTL and testbench

//  Downstream of the inner-product stage: consumes its registered partial sums (one per

---
 rtl/ip_accum_stage_pkg.sv | 17 +
 rtl/ip_accum_stage_sat.sv | 26 ++
 rtl/ip_accum_stage.sv | 77 +++++++
 tb/tb_ip_accum_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_accum_stage_pkg.sv
// Shared Axiline stage configuration: accumulator FSM states and constant helpers.
package ip_accum_stage_pkg;

   typedef enum logic {
      ACC  = 1'b0,
      FULL = 1'b1
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/ip_accum_stage_sat.sv
// Combinational signed saturation from inW bits down to outW bits, flagging clipping.
module sat_trunc #(
   parameter int inW  = 32,
   parameter int outW = 16
) (
   input  logic [inW-1:0]  in_val,
   output logic [outW-1:0] out_val,
   output logic            clipped
);

   localparam logic signed [inW-1:0] MAXV = {{(inW-outW+1){1'b0}}, {(outW-1){1'b1}}};
   localparam logic signed [inW-1:0] MINV = {{(inW-outW+1){1'b1}}, {(outW-1){1'b0}}};

   always_comb begin
      out_val = in_val[outW-1:0];
      clipped = 1'b0;
      if ($signed(in_val) > MAXV) begin
         out_val = MAXV[outW-1:0];
         clipped = 1'b1;
      end else if ($signed(in_val) < MINV) begin
         out_val = MINV[outW-1:0];
         clipped = 1'b1;
      end
   end

endmodule

// File: rtl/ip_accum_stage.sv
// Accumulates numChunks partial inner products into one saturated dot product,
// offered on a valid/ready output.
module ip_accum_stage
   import ip_accum_stage_pkg::*;
#(
   parameter int bitwidth    = 16,
   parameter int accBitwidth = 32,
   parameter int numChunks   = 4,
   parameter int cntWidth    = (clog2(numChunks) > 0) ? clog2(numChunks) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [bitwidth-1:0] in_sum,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [bitwidth-1:0] out_sum,
   output logic                out_sat,
   output logic [cntWidth-1:0] chunk_idx
);

   localparam logic [cntWidth-1:0] LAST_IDX = cntWidth'(numChunks - 1);

   state_t                         state, state_nxt;
   logic signed [accBitwidth-1:0]  acc, in_ext, total;
   logic [bitwidth-1:0]            sat_val;
   logic                           sat_clip;
   logic                           accept, last;

   assign in_ready  = (state == ACC) || out_ready;
   assign out_valid = (state == FULL);
   assign accept    = in_valid && in_ready;
   assign last      = (chunk_idx == LAST_IDX);
   assign in_ext    = accBitwidth'($signed(in_sum));
   // Chunk 0 ignores whatever the previous vector left in acc.
   assign total     = ((chunk_idx == '0) ? '0 : acc) + in_ext;

   sat_trunc #(.inW(accBitwidth), .outW(bitwidth)) u_sat (
      .in_val  (total),
      .out_val (sat_val),
      .clipped (sat_clip)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACC;
      else     state <= state_nxt;
   end

   // An accept in FULL implies out_ready, so it is always a simultaneous pop+push.
   always_comb begin
      state_nxt = state;
      if (accept && last)
         state_nxt = FULL;
      else if (accept || (state == FULL && out_ready))
         state_nxt = ACC;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         chunk_idx <= '0;
         out_sum   <= '0;
         out_sat   <= 1'b0;
      end else if (accept) begin
         if (last) begin
            out_sum   <= sat_val;
            out_sat   <= sat_clip;
            chunk_idx <= '0;
         end else begin
            acc       <= total;
            chunk_idx <= chunk_idx + cntWidth'(1);
         end
      end
   end

endmodule

// File: tb/tb_ip_accum_stage.sv
// Self-checking bench for ip_accum_stage: directed/random vector table, corner
// sequences, and a randomized handshake stress against a behavioural model.
module tb_ip_accum_stage;

   typedef logic [3:0][15:0] chunks_t;
   typedef struct {
      chunks_t     s;
      logic [15:0] exp;
      logic        sat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b1;
   logic [15:0] in_sum = '0;
   logic        in_ready, out_valid, out_sat;
   logic [15:0] out_sum;
   logic [1:0]  chunk_idx;

   logic        in_valid1 = 1'b0, out_ready1 = 1'b1;
   logic [15:0] in_sum1 = '0;
   logic        in_ready1, out_valid1, out_sat1;
   logic [15:0] out_sum1;
   logic [0:0]  chunk_idx1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ip_accum_stage #(.bitwidth(16), .accBitwidth(32), .numChunks(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_sat(out_sat),
      .chunk_idx(chunk_idx)
   );

   ip_accum_stage #(.bitwidth(16), .accBitwidth(32), .numChunks(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_sum(in_sum1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1), .out_sat(out_sat1),
      .chunk_idx(chunk_idx1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain sum of the signed chunks, then clamp to 16-bit range.
   function automatic void model(input chunks_t s, output logic [15:0] o, output logic c);
      longint t;
      t = 0;
      for (int i = 0; i < 4; i++) t += longint'($signed(s[i]));
      clamp(t, o, c);
   endfunction

   function automatic void clamp(input longint t, output logic [15:0] o, output logic c);
      c = 1'b1;
      if (t > 32767)       o = 16'h7FFF;
      else if (t < -32768) o = 16'h8000;
      else begin
         o = t[15:0];
         c = 1'b0;
      end
   endfunction

   task automatic feed(input logic [15:0] v);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_sum   = v;
      #1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL feed_timeout: in_ready stuck at %0d expected 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("drain_valid", 32'(out_valid), 32'd0);
   endtask

   vec_t   tbl[12];
   chunks_t rc;

   bit          m_full;
   logic [15:0] m_res;
   logic        m_sat;
   longint      m_acc;
   int          m_cnt;
   logic        push;

   initial begin
      #2;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sum",   32'(out_sum),   32'd0);
      check("rst_sat",   32'(out_sat),   32'd0);
      check("rst_idx",   32'(chunk_idx), 32'd0);
      check("rst_ready", 32'(in_ready),  32'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed rows with hand-derived expectations, then random rows from the model.
      tbl[0] = '{s: {16'd7, 16'hFFFB, 16'd20, 16'd10},   exp: 16'd32,    sat: 1'b0};
      tbl[1] = '{s: {4{16'h7FFF}},                        exp: 16'h7FFF,  sat: 1'b1};
      tbl[2] = '{s: {4{16'h8000}},                        exp: 16'h8000,  sat: 1'b1};
      tbl[3] = '{s: {16'd0, 16'd1, 16'd16383, 16'd16383}, exp: 16'h7FFF,  sat: 1'b0};
      tbl[4] = '{s: {16'd0, 16'd1, 16'd16384, 16'd16383}, exp: 16'h7FFF,  sat: 1'b1};
      tbl[5] = '{s: {16'd0, 16'd0, 16'hC000, 16'hC000},   exp: 16'h8000,  sat: 1'b0};
      tbl[6] = '{s: {16'hFFFF, 16'd0, 16'hC000, 16'hC000}, exp: 16'h8000, sat: 1'b1};
      for (int i = 7; i < 12; i++) begin
         for (int k = 0; k < 4; k++) rc[k] = 16'($urandom_range(0, 65535));
         tbl[i].s = rc;
         model(rc, tbl[i].exp, tbl[i].sat);
      end

      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         for (int k = 0; k < 4; k++) begin
            check($sformatf("v%0d_idx%0d", i, k), 32'(chunk_idx), 32'(k));
            if (k < 3 && i > 0) check($sformatf("v%0d_nv%0d", i, k), 32'(out_valid), 32'd0);
            feed(tbl[i].s[k]);
         end
         check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("v%0d_sum", i),   32'(out_sum),   32'(tbl[i].exp));
         check($sformatf("v%0d_sat", i),   32'(out_sat),   32'(tbl[i].sat));
         @(posedge clk); #1;
         check($sformatf("v%0d_onecyc", i), 32'(out_valid), 32'd0);
      end

      // Backpressure: result held while consumer stalls, inputs refused.
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) feed(16'd9);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum",   32'(out_sum),   32'd36);
      in_valid = 1'b1;
      in_sum   = 16'd555;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_inready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_sum",   32'(out_sum),   32'd36);
         check("bp_hold_idx",   32'(chunk_idx), 32'd0);
      end
      drain();
      for (int k = 0; k < 4; k++) feed(16'd1);
      check("bp_next_valid", 32'(out_valid), 32'd1);
      check("bp_next_sum",   32'(out_sum),   32'd4);

      // Pop and push in the same cycle: the pushed value is chunk 0 of the next vector.
      drain();
      for (int k = 0; k < 4; k++) feed(16'd5);
      check("pp_first", 32'(out_sum), 32'd20);
      in_valid = 1'b1;
      in_sum   = 16'd100;
      #1;
      check("pp_inready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("pp_popped", 32'(out_valid), 32'd0);
      check("pp_idx",    32'(chunk_idx), 32'd1);
      for (int k = 0; k < 3; k++) feed(16'd1);
      check("pp_valid", 32'(out_valid), 32'd1);
      check("pp_sum",   32'(out_sum),   32'd103);
      drain();

      // Reset mid-vector discards the partial sum.
      feed(16'd50);
      feed(16'd50);
      check("mr_idx_before", 32'(chunk_idx), 32'd2);
      rst = 1'b1;
      #1;
      check("mr_idx_rst",   32'(chunk_idx), 32'd0);
      check("mr_valid_rst", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 1; k <= 4; k++) feed(16'(k));
      check("mr_valid", 32'(out_valid), 32'd1);
      check("mr_sum",   32'(out_sum),   32'd10);
      drain();

      // Random handshake stress against a chunk-list model.
      m_full = 1'b0; m_acc = 0; m_cnt = 0; m_res = '0; m_sat = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         in_sum    = 16'($urandom_range(0, 65535));
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         check("st_inready", 32'(in_ready),  32'(!m_full || out_ready));
         check("st_valid",   32'(out_valid), 32'(m_full));
         if (m_full) begin
            check("st_sum", 32'(out_sum), 32'(m_res));
            check("st_sat", 32'(out_sat), 32'(m_sat));
         end
         push = in_valid && (!m_full || out_ready);
         if (m_full && out_ready) m_full = 1'b0;
         if (push) begin
            m_acc += longint'($signed(in_sum));
            m_cnt++;
            if (m_cnt == 4) begin
               clamp(m_acc, m_res, m_sat);
               m_full = 1'b1;
               m_acc  = 0;
               m_cnt  = 0;
            end
         end
         @(posedge clk); #1;
      end
      drain();

      // Single-chunk configuration: every input is a complete vector.
      out_ready1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid1 = 1'b1;
         in_sum1   = (i == 0) ? 16'd3 : (i == 1) ? 16'hFFFC : 16'd5;
         #1;
         check("n1_inready", 32'(in_ready1), 32'd1);
         @(posedge clk); #1;
         check($sformatf("n1_valid%0d", i), 32'(out_valid1), 32'd1);
         check($sformatf("n1_sum%0d", i),   32'(out_sum1),   32'(in_sum1));
         check($sformatf("n1_sat%0d", i),   32'(out_sat1),   32'd0);
         check($sformatf("n1_idx%0d", i),   32'(chunk_idx1), 32'd0);
      end
      in_valid1 = 1'b0;
      @(posedge clk); #1;
      check("n1_drain", 32'(out_valid1), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
